// File: rtl/transport_snd_if.sv
// Session/network-side signal bundle for the transmit transport stage.
interface transport_snd_if;
    logic        ctrl_valid;
    logic [1:0]  ctrl_cmd;
    logic [7:0]  ctrl_phone;
    logic [15:0] ctrl_data;
    logic        ctrl_ready;
    logic        audio_valid;
    logic [7:0]  audio_phone;
    logic [15:0] audio_sample;
    logic        audio_ready;
    logic        net_ready;
    logic        send_signal;
    logic [7:0]  packet_out;
    logic        busy;

    // Upstream session + downstream network view (drives requests, consumes bytes).
    modport master (
        output ctrl_valid, ctrl_cmd, ctrl_phone, ctrl_data,
        output audio_valid, audio_phone, audio_sample,
        output net_ready,
        input  ctrl_ready, audio_ready, send_signal, packet_out, busy
    );

    // Transport stage view.
    modport slave (
        input  ctrl_valid, ctrl_cmd, ctrl_phone, ctrl_data,
        input  audio_valid, audio_phone, audio_sample,
        input  net_ready,
        output ctrl_ready, audio_ready, send_signal, packet_out, busy
    );
endinterface

// File: rtl/transport_snd.sv
// Transmit transport stage: frames control commands and batched audio samples
// into fixed-size byte packets and streams them under a ready handshake.
module transport_snd #(
    parameter int unsigned PACKET_BYTES = 16,
    parameter logic [7:0]  HDR_CTRL     = 8'h40,
    parameter logic [7:0]  HDR_AUDIO    = 8'h80
) (
    input  logic             clk,
    input  logic             reset,
    transport_snd_if.slave   bus
);

    localparam int unsigned AUDIO_SAMPLES = (PACKET_BYTES - 2) / 2;
    localparam int unsigned IDX_W         = $clog2(PACKET_BYTES);
    localparam int unsigned CNT_W         = $clog2(AUDIO_SAMPLES + 1);
    localparam int unsigned SEL_W         = (AUDIO_SAMPLES > 1) ? $clog2(AUDIO_SAMPLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(AUDIO_SAMPLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                           state_q, state_d;
    logic                             is_audio_q, is_audio_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [1:0]                       cmd_q, cmd_d;
    logic [7:0]                       cphone_q, cphone_d;
    logic [15:0]                      cdata_q, cdata_d;
    logic [7:0]                       aphone_q, aphone_d;
    logic [AUDIO_SAMPLES-1:0][15:0]   samples_q, samples_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             send_q, send_d;
    logic                             busy_q, busy_d;
    logic [7:0]                       pkt_q, pkt_d;

    logic                             ctrl_acc;
    logic                             audio_acc;
    logic                             xfer;
    logic [IDX_W-1:0]                 off;
    logic [SEL_W-1:0]                 sel;
    logic [15:0]                      word;

    // Ready flags are decoded straight from state so the session sees them in the same cycle.
    assign bus.ctrl_ready  = (state_q == IDLE);
    assign bus.audio_ready = (cnt_q < FULL_CNT);
    assign bus.send_signal = send_q;
    assign bus.busy        = busy_q;
    assign bus.packet_out  = pkt_q;

    // State register and latched payloads.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            is_audio_q <= 1'b0;
            idx_q      <= '0;
            cmd_q      <= '0;
            cphone_q   <= '0;
            cdata_q    <= '0;
            aphone_q   <= '0;
            samples_q  <= '0;
            cnt_q      <= '0;
            send_q     <= 1'b0;
            busy_q     <= 1'b0;
            pkt_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            is_audio_q <= is_audio_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            cphone_q   <= cphone_d;
            cdata_q    <= cdata_d;
            aphone_q   <= aphone_d;
            samples_q  <= samples_d;
            cnt_q      <= cnt_d;
            send_q     <= send_d;
            busy_q     <= busy_d;
            pkt_q      <= pkt_d;
        end
    end

    // Next-state: audio accumulation, control/audio launch and byte advance.
    always_comb begin
        state_d    = state_q;
        is_audio_d = is_audio_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        cphone_d   = cphone_q;
        cdata_d    = cdata_q;
        aphone_d   = aphone_q;
        samples_d  = samples_q;
        cnt_d      = cnt_q;

        ctrl_acc  = bus.ctrl_valid && (state_q == IDLE);
        audio_acc = bus.audio_valid && (cnt_q < FULL_CNT);
        xfer      = send_q && bus.net_ready;

        // Audio slots fill independently of transmission; phone comes from the first sample only.
        if (audio_acc) begin
            samples_d[SEL_W'(cnt_q)] = bus.audio_sample;
            if (cnt_q == '0) begin
                aphone_d = bus.audio_phone;
            end
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (ctrl_acc) begin
                    cmd_d      = bus.ctrl_cmd;
                    cphone_d   = bus.ctrl_phone;
                    cdata_d    = bus.ctrl_data;
                    state_d    = SEND;
                    is_audio_d = 1'b0;
                    idx_d      = '0;
                end else if (cnt_q == FULL_CNT) begin
                    state_d    = SEND;
                    is_audio_d = 1'b1;
                    idx_d      = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        // The buffer is free again only once its packet has fully left.
                        if (is_audio_q) begin
                            cnt_d = '0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase

        send_d = (state_d == SEND);
        busy_d = (state_d == SEND);
    end

    // Byte map for the next cycle's packet_out, driven from next-state index and payloads.
    always_comb begin
        off   = idx_d - IDX_W'(2);
        sel   = SEL_W'(off >> 1);
        word  = (32'(sel) < AUDIO_SAMPLES) ? samples_d[sel] : 16'h0000;
        pkt_d = 8'h00;
        if (state_d == SEND) begin
            if (idx_d == '0) begin
                pkt_d = is_audio_d ? HDR_AUDIO : HDR_CTRL;
            end else if (idx_d == IDX_W'(1)) begin
                pkt_d = is_audio_d ? aphone_d : cphone_d;
            end else if (is_audio_d) begin
                pkt_d = off[0] ? word[7:0] : word[15:8];
            end else if (idx_d == IDX_W'(2)) begin
                pkt_d = {6'b000000, cmd_d};
            end else if (idx_d == IDX_W'(3)) begin
                pkt_d = cdata_d[15:8];
            end else if (idx_d == IDX_W'(4)) begin
                pkt_d = cdata_d[7:0];
            end
        end
    end

endmodule
